// File: rtl/pll_ctrl_pkg.sv
// Shared types and default timing for the system PLL reset sequencer.
// Defaults assume a 50 MHz reference clock.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  localparam int unsigned DefRstCycles    = 16;
  localparam int unsigned DefLockTimeout  = 65535;  // ~1.3 ms
  localparam int unsigned DefStableCycles = 1024;
  localparam int unsigned DefMaxRetries   = 7;
  localparam int unsigned DefCntW         = 16;

  // Saturating 4-bit increment for the retry counter.
  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hf) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= ResetVal;
      q    <= ResetVal;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset / lock qualification sequencer: holds the PLL in reset, waits for a stable lock
// with timeout and retry limit, then releases the downstream system reset.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DefRstCycles,
  parameter int unsigned LOCK_TIMEOUT  = DefLockTimeout,
  parameter int unsigned STABLE_CYCLES = DefStableCycles,
  parameter int unsigned MAX_RETRIES   = DefMaxRetries,
  parameter int unsigned CNT_W         = DefCntW
) (
  input  logic       refclk,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       soft_reset_req,
  output logic       pll_reset,
  output logic       sys_reset_n,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] retry_cnt
);

  localparam logic [CNT_W-1:0] RstLast  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ToLast   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StbLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam logic [3:0]       RetryMax = 4'(MAX_RETRIES);

  logic lock_s;

  sync_2ff #(
    .ResetVal(1'b0)
  ) u_lock_sync (
    .clk  (refclk),
    .rst_n(reset_n),
    .d    (pll_lock),
    .q    (lock_s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] stb_cnt_q, stb_cnt_d;
  logic [3:0]       retry_q, retry_d, retry_inc;
  logic             lost_q, lost_d;
  logic             timeout;

  always_comb begin
    retry_inc = sat_inc4(retry_q);
    timeout   = (to_cnt_q == ToLast);
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    to_cnt_d  = to_cnt_q;
    stb_cnt_d = stb_cnt_q;
    retry_d   = retry_q;
    lost_d    = lost_q;

    if (soft_reset_req) begin
      state_d   = RESET_PLL;
      rst_cnt_d = '0;
      to_cnt_d  = '0;
      stb_cnt_d = '0;
      retry_d   = '0;
      lost_d    = 1'b0;
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (rst_cnt_q == RstLast) begin
            state_d   = WAIT_LOCK;
            rst_cnt_d = '0;
            to_cnt_d  = '0;
            stb_cnt_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + CntOne;
          end
        end
        WAIT_LOCK, STABLE: begin
          // Timeout outranks any lock-based transition in the same cycle.
          if (timeout) begin
            retry_d   = retry_inc;
            rst_cnt_d = '0;
            to_cnt_d  = '0;
            stb_cnt_d = '0;
            state_d   = (retry_inc == RetryMax) ? FAIL : RESET_PLL;
          end else begin
            to_cnt_d = to_cnt_q + CntOne;
            if (state_q == WAIT_LOCK) begin
              if (lock_s) begin
                state_d   = STABLE;
                stb_cnt_d = '0;
              end
            end else if (!lock_s) begin
              state_d   = WAIT_LOCK;
              stb_cnt_d = '0;
            end else if (stb_cnt_q == StbLast) begin
              state_d   = RUN;
              retry_d   = '0;
              to_cnt_d  = '0;
              stb_cnt_d = '0;
            end else begin
              stb_cnt_d = stb_cnt_q + CntOne;
            end
          end
        end
        RUN: begin
          if (!lock_s) begin
            state_d   = RESET_PLL;
            rst_cnt_d = '0;
            lost_d    = 1'b1;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d   = RESET_PLL;
          rst_cnt_d = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_PLL;
      rst_cnt_q   <= '0;
      to_cnt_q    <= '0;
      stb_cnt_q   <= '0;
      retry_q     <= '0;
      lost_q      <= 1'b0;
      pll_reset   <= 1'b1;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      to_cnt_q    <= to_cnt_d;
      stb_cnt_q   <= stb_cnt_d;
      retry_q     <= retry_d;
      lost_q      <= lost_d;
      pll_reset   <= (state_d == RESET_PLL) || (state_d == FAIL);
      sys_reset_n <= (state_d == RUN);
      ready       <= (state_d == RUN);
      fail        <= (state_d == FAIL);
    end
  end

  assign retry_cnt = retry_q;
  assign lock_lost = lost_q;

endmodule
